sm_dmem_responder: RTL and testbench

SM_DMEM_RESPONDER -- requirements
Module: sm_dmem_responder

---
 rtl/sm_dmem_responder_pkg.sv | 39 +++
 rtl/sm_dmem_responder_if.sv | 15 +
 rtl/sm_dmem_responder_fifo.sv | 46 ++++
 rtl/sm_dmem_responder.sv | 113 +++++++++++
 tb/tb_sm_dmem_responder.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/sm_dmem_responder_pkg.sv
// Shared address map and register bit layout for the data-memory responder.
// Both the RTL and the software-side tests use these constants.
package sm_dmem_responder_pkg;

  localparam int SEL_BIT = 31;  // 0 = RAM, 1 = MMIO

  localparam logic [3:0] OFF_GPIO_OUT  = 4'd0;
  localparam logic [3:0] OFF_GPIO_IN   = 4'd1;
  localparam logic [3:0] OFF_TIMER_CNT = 4'd2;
  localparam logic [3:0] OFF_TIMER_CMP = 4'd3;
  localparam logic [3:0] OFF_STATUS    = 4'd4;
  localparam logic [3:0] OFF_TX_DATA   = 4'd5;
  localparam logic [3:0] OFF_CTRL      = 4'd6;

  localparam int ST_MATCH  = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_EMPTY  = 2;
  localparam int ST_CNT_LO = 3;
  localparam int ST_CNT_HI = 6;
  localparam int ST_OVF    = 7;

  localparam int CTRL_IE  = 0;
  localparam int CTRL_TEN = 1;

  // A 16-deep FIFO holding 16 bytes does not fit the 4-bit field; it reads as 0.
  function automatic logic [31:0] pack_status(input logic match, input logic full,
                                               input logic empty, input logic [4:0] cnt,
                                               input logic ovf);
    logic [31:0] s;
    s = '0;
    s[ST_MATCH]            = match;
    s[ST_FULL]             = full;
    s[ST_EMPTY]            = empty;
    s[ST_CNT_HI:ST_CNT_LO] = cnt[3:0];
    s[ST_OVF]              = ovf;
    return s;
  endfunction

endpackage

// File: rtl/sm_dmem_responder_if.sv
// CPU data bus plus TX byte stream between the responder and its users.
interface sm_dmem_responder_if;
  logic [31:0] dmAddr;
  logic        dmWe;
  logic [31:0] dmWData;
  logic [31:0] dmRData;
  logic [7:0]  txData;
  logic        txValid;
  logic        txReady;

  modport master (output dmAddr, dmWe, dmWData, txReady,
                  input  dmRData, txData, txValid);
  modport slave  (input  dmAddr, dmWe, dmWData, txReady,
                  output dmRData, txData, txValid);
endinterface

// File: rtl/sm_dmem_responder_fifo.sv
// Synchronous FIFO; DEPTH is a power of two so pointers wrap for free.
module sm_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/sm_dmem_responder.sv
// Data-memory responder: word RAM below the select bit, GPIO/timer/TX FIFO
// registers above it. Reads are combinational, writes commit on the edge.
module sm_dmem_responder
  import sm_dmem_responder_pkg::*;
#(
  parameter int RAM_WORDS = 64,
  parameter int TXF_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  sm_dmem_responder_if.slave   bus,
  input  logic [15:0]          gpioIn,
  output logic [15:0]          gpioOut,
  output logic                 irq
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(TXF_DEPTH + 1);

  logic [31:0]       ram [RAM_WORDS];
  logic              is_mmio;
  logic [3:0]        off;
  logic [AW-1:0]     ram_idx;
  logic              wr_en, wr_ram, wr_gpio, wr_cnt, wr_cmp, wr_stat, wr_tx, wr_ctrl;
  logic [1:0][15:0]  gpio_sync;
  logic [31:0]       timer_cnt, timer_cmp;
  logic              ctrl_ie, ctrl_ten, match, ovf;
  logic              match_set, ovf_set;
  logic              txf_full, txf_empty;
  logic [CW-1:0]     txf_cnt;
  logic [31:0]       rdata;
  logic              unused_addr;

  assign is_mmio     = bus.dmAddr[SEL_BIT];
  assign off         = bus.dmAddr[3:0];
  assign ram_idx     = bus.dmAddr[AW-1:0];
  assign unused_addr = ^bus.dmAddr[30:AW];

  // Writes issued in the reset cycle are dropped everywhere, RAM included.
  assign wr_en   = bus.dmWe & ~rst;
  assign wr_ram  = wr_en & ~is_mmio;
  assign wr_gpio = wr_en & is_mmio & (off == OFF_GPIO_OUT);
  assign wr_cnt  = wr_en & is_mmio & (off == OFF_TIMER_CNT);
  assign wr_cmp  = wr_en & is_mmio & (off == OFF_TIMER_CMP);
  assign wr_stat = wr_en & is_mmio & (off == OFF_STATUS);
  assign wr_tx   = wr_en & is_mmio & (off == OFF_TX_DATA);
  assign wr_ctrl = wr_en & is_mmio & (off == OFF_CTRL);

  assign match_set = ctrl_ten & (timer_cnt == timer_cmp);
  assign ovf_set   = wr_tx & txf_full;
  assign irq       = match & ctrl_ie;

  always_ff @(posedge clk)
    if (wr_ram) ram[ram_idx] <= bus.dmWData;

  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_sync <= '0;
      gpioOut   <= '0;
      timer_cnt <= '0;
      timer_cmp <= '0;
      ctrl_ie   <= 1'b0;
      ctrl_ten  <= 1'b0;
      match     <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      gpio_sync[1] <= gpio_sync[0];
      gpio_sync[0] <= gpioIn;
      if (wr_gpio) gpioOut <= bus.dmWData[15:0];
      if (wr_cnt)        timer_cnt <= bus.dmWData;
      else if (ctrl_ten) timer_cnt <= timer_cnt + 32'd1;
      if (wr_cmp) timer_cmp <= bus.dmWData;
      if (wr_ctrl) begin
        ctrl_ie  <= bus.dmWData[CTRL_IE];
        ctrl_ten <= bus.dmWData[CTRL_TEN];
      end
      // Sticky bits: a same-cycle set beats the write-one-to-clear.
      match <= match_set | (match & ~(wr_stat & bus.dmWData[ST_MATCH]));
      ovf   <= ovf_set   | (ovf   & ~(wr_stat & bus.dmWData[ST_OVF]));
    end
  end

  sm_fifo #(.W(8), .DEPTH(TXF_DEPTH)) u_txf (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_tx & ~txf_full),
    .din   (bus.dmWData[7:0]),
    .pop   (bus.txValid & bus.txReady),
    .dout  (bus.txData),
    .full  (txf_full),
    .empty (txf_empty),
    .count (txf_cnt)
  );

  assign bus.txValid = ~txf_empty;

  always_comb begin
    rdata = '0;
    if (!is_mmio) rdata = ram[ram_idx];
    else begin
      case (off)
        OFF_GPIO_OUT:  rdata = {16'h0, gpioOut};
        OFF_GPIO_IN:   rdata = {16'h0, gpio_sync[1]};
        OFF_TIMER_CNT: rdata = timer_cnt;
        OFF_TIMER_CMP: rdata = timer_cmp;
        OFF_STATUS:    rdata = pack_status(match, txf_full, txf_empty, 5'(txf_cnt), ovf);
        OFF_CTRL:      rdata = {30'h0, ctrl_ten, ctrl_ie};
        default:       rdata = '0;
      endcase
    end
  end

  assign bus.dmRData = rdata;
endmodule

// File: tb/tb_sm_dmem_responder.sv
// Directed checks of RAM aliasing, GPIO, timer/match, TX FIFO and reset.
module tb_sm_dmem_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] gpioIn = '0;
  logic [15:0] gpioOut;
  logic        irq;
  int          n_cmp = 0;
  int          n_err = 0;

  localparam logic [31:0] A_GPO  = 32'h8000_0000;
  localparam logic [31:0] A_GPI  = 32'h8000_0001;
  localparam logic [31:0] A_CNT  = 32'h8000_0002;
  localparam logic [31:0] A_CMP  = 32'h8000_0003;
  localparam logic [31:0] A_STAT = 32'h8000_0004;
  localparam logic [31:0] A_TX   = 32'h8000_0005;
  localparam logic [31:0] A_CTRL = 32'h8000_0006;

  sm_dmem_responder_if bus ();

  sm_dmem_responder #(.RAM_WORDS(64), .TXF_DEPTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .gpioIn  (gpioIn),
    .gpioOut (gpioOut),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; consumes exactly one rising edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.dmAddr  = a;
    bus.dmWData = d;
    bus.dmWe    = 1'b1;
    @(negedge clk);
    bus.dmWe    = 1'b0;
  endtask

  task automatic rchk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.dmAddr = a;
    #1;
    chk(tag, bus.dmRData, exp);
  endtask

  initial begin
    logic [7:0] exp_bytes [4];
    exp_bytes[0] = 8'h11; exp_bytes[1] = 8'h22; exp_bytes[2] = 8'h33; exp_bytes[3] = 8'h44;
    bus.dmAddr = '0; bus.dmWe = 1'b0; bus.dmWData = '0; bus.txReady = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // reset state
    chk("rst_txvalid", {31'h0, bus.txValid}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_gpioout", {16'h0, gpioOut}, 32'h0);
    rchk("rst_status", A_STAT, 32'h04);
    rchk("rst_cnt", A_CNT, 32'h0);

    // RAM and aliasing; unmapped / write-only reads
    wr(32'd5, 32'hDEAD_BEEF);
    rchk("ram_5", 32'd5, 32'hDEAD_BEEF);
    rchk("ram_alias", 32'd69, 32'hDEAD_BEEF);
    rchk("unmapped_7", 32'h8000_0007, 32'h0);
    rchk("unmapped_f", 32'h8000_000F, 32'h0);
    rchk("txdata_rd", A_TX, 32'h0);

    // GPIO synchronizer latency and output width
    gpioIn = 16'hA5A5;
    rchk("gpi_0edge", A_GPI, 32'h0);
    @(negedge clk);
    rchk("gpi_1edge", A_GPI, 32'h0);
    @(negedge clk);
    rchk("gpi_2edge", A_GPI, 32'h0000_A5A5);
    wr(A_GPO, 32'h1234_ABCD);
    chk("gpo_pin", {16'h0, gpioOut}, 32'h0000_ABCD);
    rchk("gpo_rd", A_GPO, 32'h0000_ABCD);

    // Timer match and irq
    wr(A_CMP, 32'd10);
    wr(A_CNT, 32'd0);
    wr(A_CTRL, 32'd3);
    repeat (10) @(negedge clk);
    rchk("tmr_cnt10", A_CNT, 32'd10);
    rchk("tmr_nomatch", A_STAT, 32'h04);
    @(negedge clk);
    rchk("tmr_match", A_STAT, 32'h05);
    chk("tmr_irq", {31'h0, irq}, 32'h1);
    wr(A_STAT, 32'h1);
    rchk("tmr_w1c", A_STAT, 32'h04);
    chk("tmr_irq_clr", {31'h0, irq}, 32'h0);
    wr(A_CNT, 32'd5);
    rchk("tmr_wr_prio", A_CNT, 32'd5);
    repeat (5) @(negedge clk);
    rchk("tmr_cnt_again", A_CNT, 32'd10);
    wr(A_STAT, 32'h1);
    rchk("tmr_set_wins", A_STAT, 32'h05);
    wr(A_CTRL, 32'd0);

    // FIFO fill past full with consumer stalled
    chk("txf_empty_valid", {31'h0, bus.txValid}, 32'h0);
    wr(A_TX, 32'h11);
    chk("txf_valid_next", {31'h0, bus.txValid}, 32'h1);
    wr(A_TX, 32'h22);
    wr(A_TX, 32'h33);
    wr(A_TX, 32'h44);
    wr(A_TX, 32'h55);
    rchk("txf_full_stat", A_STAT, 32'hA3);
    repeat (2) @(negedge clk);
    chk("txf_hold", {24'h0, bus.txData}, 32'h11);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("txf_drain%0d", i), {24'h0, bus.txData}, {24'h0, exp_bytes[i]});
      bus.txReady = 1'b1;
      @(negedge clk);
    end
    chk("txf_drained", {31'h0, bus.txValid}, 32'h0);
    bus.txReady = 1'b0;

    // Simultaneous push and pop at count 2
    wr(A_TX, 32'hA1);
    wr(A_TX, 32'hA2);
    rchk("pp_cnt2", A_STAT, 32'h91);
    bus.txReady = 1'b1;
    wr(A_TX, 32'hA3);
    rchk("pp_cnt_same", A_STAT, 32'h91);
    chk("pp_head_a2", {24'h0, bus.txData}, 32'hA2);
    @(negedge clk);
    chk("pp_head_a3", {24'h0, bus.txData}, 32'hA3);
    @(negedge clk);
    chk("pp_empty", {31'h0, bus.txValid}, 32'h0);
    bus.txReady = 1'b0;
    wr(A_STAT, 32'h80);
    rchk("ovf_w1c", A_STAT, 32'h05);

    // Reset mid-operation with bytes queued and timer running
    wr(A_CTRL, 32'd2);
    wr(A_TX, 32'h01);
    wr(A_TX, 32'h02);
    wr(A_TX, 32'h03);
    bus.dmAddr = A_GPO; bus.dmWData = 32'hFFFF; bus.dmWe = 1'b1; rst = 1'b1;
    @(negedge clk);
    bus.dmWe = 1'b0;
    chk("mid_rst_valid", {31'h0, bus.txValid}, 32'h0);
    rchk("mid_rst_cnt", A_CNT, 32'h0);
    rchk("mid_rst_stat", A_STAT, 32'h04);
    chk("mid_rst_gpo", {16'h0, gpioOut}, 32'h0);
    chk("mid_rst_irq", {31'h0, irq}, 32'h0);
    rchk("mid_rst_gpi", A_GPI, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", {31'h0, bus.txValid}, 32'h0);
    rchk("post_rst_cnt", A_CNT, 32'h0);
    rchk("ram_kept", 32'd5, 32'hDEAD_BEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
